pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ILLOP_PC, default 32'h8000_0004, illegal-operation/misaligned-jump vector.
REQ-003 SHALL have parameter XADR_PC, default 32'h8000_0008, interrupt/exception vector.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  32  fetch address, equals PC register.
REQ-007 imem_req  out  1  fetch request to instruction ROM.
REQ-008 imem_ack  in  1  ROM data valid this cycle.
REQ-009 imem_rdata  in  32  ROM instruction word.
REQ-010 inst  out  32  registered instruction for datapath.
REQ-011 inst_valid  out  1  one-cycle execute strobe.
REQ-012 pc  out  32  current PC; pc_plus4 out 32 = pc+4.
REQ-013 pc_src  in  3  next-PC select, sampled only when inst_valid=1.
REQ-014 branch_taken  in  1; imm16  in  16; jidx  in  26; jr_addr  in  32: target operands from decoder/ALU.
REQ-015 halt  in  1  stop after current instruction.
REQ-016 irq  in  1  level interrupt request.
REQ-017 epc  out  32  exception return address; epc_we out 1 one-cycle write pulse.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, EXEC, HALT.
REQ-019 BOOT: one cycle after reset deassertion, then FETCH; no outputs active.
REQ-020 FETCH: imem_req=1, imem_addr stable; on imem_ack=1 capture imem_rdata into inst, go EXEC next cycle; ack outside FETCH ignored.
REQ-021 EXEC: inst_valid=1 exactly one cycle; PC updated at end of EXEC; then FETCH, or HALT if halt=1.
REQ-022 Minimum throughput SHALL be 2 cycles/instruction (ack in first FETCH cycle).
REQ-023 pc_src 0: pc+4; 1: branch_taken ? pc+4+(sext(imm16)<<2) : pc+4; 2: {pc_plus4[31:28], jidx, 2'b00}; 3: jr_addr; 4: ILLOP_PC; 5: XADR_PC; 6,7: ILLOP_PC.
REQ-024 pc_src 1 and 2 SHALL preserve pc[31] (kernel bit) of current PC; pc_src 3 takes jr_addr[31] unchanged.
REQ-025 pc_src 3 with jr_addr[1:0]!=0 SHALL redirect to ILLOP_PC.
REQ-026 Any redirect to ILLOP_PC or XADR_PC SHALL set epc=pc+4 and pulse epc_we in EXEC.
REQ-027 Arithmetic SHALL be 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-028 HALT: no requests, inst_valid=0, PC frozen until reset.

Reset
REQ-029 While reset=0: state=BOOT, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, epc=0, epc_we=0, irq pending=0.
REQ-030 Reset mid-FETCH SHALL abandon the request immediately; a late ack after release SHALL be ignored until next FETCH.

Configuration
REQ-031 Macro PC_SEQ_IRQ_EN: when defined, irq sets a pending flag; in EXEC with pending=1 and pc[31]=0, next PC SHALL be XADR_PC, epc SHALL be the normally computed next PC, epc_we pulses, pending clears.
REQ-032 Interrupt SHALL not preempt a synchronous redirect (pc_src 4/5 or misaligned jr); pending stays set.
REQ-033 Without PC_SEQ_IRQ_EN: irq ignored, no pending flag, logic absent.

Structure
REQ-034 Package cpu_pkg SHALL hold pc_src encodings (PCSRC_SEQ..PCSRC_XADR), FSM state typedef, vector defaults.
REQ-035 Optional sub-module npc_calc (combinational next-PC) SHALL be the only sub-module.

Verification
REQ-036 Reset release, ack immediate -> imem_addr=0x80000000, first inst_valid at cycle 3, next addr 0x80000004.
REQ-037 pc=0x00000010, pc_src=1, taken, imm16=0xFFFE -> next pc=0x0000000C; not taken -> 0x00000014.
REQ-038 pc=0x80000020, pc_src=2, jidx=0x15 -> next pc=0x80000054.
REQ-039 pc_src=3, jr_addr=0x00000102 -> next pc=ILLOP_PC, epc=pc+4, epc_we one cycle.
REQ-040 imem_ack delayed 5 cycles -> imem_req held 5 cycles, addr stable, single inst_valid.
REQ-041 PC_SEQ_IRQ_EN, irq pulse at pc=0x00000008 pc_src=0 -> next pc=0x80000008, epc=0x0000000C; same at pc=0x80000008 -> deferred.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encodings,
// FSM state type and default vector addresses.
package cpu_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'd0;
  localparam logic [2:0] PCSRC_BR    = 3'd1;
  localparam logic [2:0] PCSRC_J     = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_XADR  = 3'd5;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  // Word-scaled, sign-extended branch offset; bit 31 is never needed
  // because branches keep the kernel bit of the current PC.
  function automatic logic [30:0] br_offset(input logic [15:0] imm);
    return {{13{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-ROM fetch bus between the PC sequencer (master) and the ROM (slave).
interface pc_sequencer_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection; o_trap flags a redirect to a vector
// (illegal op, misaligned jr or explicit exception).
module npc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_pc_src,
  input  logic        i_branch_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_jidx,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_trap
);

  logic [30:0] w_br_low;

  assign o_pc_plus4 = i_pc + 32'd4;
  assign w_br_low   = o_pc_plus4[30:0] + br_offset(i_imm16);

  always_comb begin
    o_next_pc = o_pc_plus4;
    o_trap    = 1'b0;
    case (i_pc_src)
      PCSRC_SEQ: o_next_pc = o_pc_plus4;
      PCSRC_BR:  o_next_pc = {i_pc[31], (i_branch_taken ? w_br_low : o_pc_plus4[30:0])};
      PCSRC_J:   o_next_pc = {i_pc[31], o_pc_plus4[30:28], i_jidx, 2'b00};
      PCSRC_JR: begin
        if (i_jr_addr[1:0] != 2'b00) begin
          o_next_pc = ILLOP_PC;
          o_trap    = 1'b1;
        end else begin
          o_next_pc = i_jr_addr;
        end
      end
      PCSRC_XADR: begin
        o_next_pc = XADR_PC;
        o_trap    = 1'b1;
      end
      default: begin
        o_next_pc = ILLOP_PC;
        o_trap    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT/FETCH/EXEC/HALT fetch loop with vectored redirects.
// Define PC_SEQ_IRQ_EN to enable the level-interrupt pending flag.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        imem,
  output logic [31:0]           o_inst,
  output logic                  o_inst_valid,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus4,
  input  logic [2:0]            i_pc_src,
  input  logic                  i_branch_taken,
  input  logic [15:0]           i_imm16,
  input  logic [25:0]           i_jidx,
  input  logic [31:0]           i_jr_addr,
  input  logic                  i_halt,
  input  logic                  i_irq,
  output logic [31:0]           o_epc,
  output logic                  o_epc_we
);

  seq_state_e  r_state;
  seq_state_e  w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_epc;
  logic [31:0] w_npc;
  logic [31:0] w_pc_plus4;
  logic        w_trap;
  logic [31:0] w_next_pc;
  logic [31:0] w_epc_val;
  logic        w_epc_we;
  logic        w_pc_we;
  logic        w_irq_take;

  npc_calc #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_npc_calc (
    .i_pc           (r_pc),
    .i_pc_src       (i_pc_src),
    .i_branch_taken (i_branch_taken),
    .i_imm16        (i_imm16),
    .i_jidx         (i_jidx),
    .i_jr_addr      (i_jr_addr),
    .o_pc_plus4     (w_pc_plus4),
    .o_next_pc      (w_npc),
    .o_trap         (w_trap)
  );

`ifdef PC_SEQ_IRQ_EN
  logic r_irq_pend;

  // Kernel-mode code and synchronous traps hold the interrupt off.
  assign w_irq_take = (r_state == EXEC) && r_irq_pend && !r_pc[31] && !w_trap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_pend <= 1'b0;
    end else if (w_irq_take) begin
      r_irq_pend <= 1'b0;
    end else if (i_irq) begin
      r_irq_pend <= 1'b1;
    end
  end
`else
  logic w_unused_irq;
  assign w_unused_irq = i_irq;
  assign w_irq_take   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_we      = 1'b0;
    w_epc_we     = 1'b0;
    w_next_pc    = w_npc;
    w_epc_val    = w_pc_plus4;
    case (r_state)
      BOOT:  w_state_next = FETCH;
      FETCH: if (imem.imem_ack) w_state_next = EXEC;
      EXEC: begin
        w_state_next = i_halt ? HALT : FETCH;
        w_pc_we      = 1'b1;
        w_epc_we     = w_trap;
        if (w_irq_take) begin
          w_next_pc = XADR_PC;
          w_epc_val = w_npc;
          w_epc_we  = 1'b1;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == FETCH && imem.imem_ack) r_inst <= imem.imem_rdata;
      if (w_pc_we) r_pc <= w_next_pc;
      if (w_epc_we) r_epc <= w_epc_val;
    end
  end

  assign imem.imem_addr = r_pc;
  assign imem.imem_req  = (r_state == FETCH);
  assign o_inst         = r_inst;
  assign o_inst_valid   = (r_state == EXEC);
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_epc_we       = w_epc_we;
  assign o_epc          = w_epc_we ? w_epc_val : r_epc;

endmodule
